mult_seq_ctrl: RTL and testbench
================================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter N, default 4, multiplier operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one multiply; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 b_lsb  input  1  current LSB of the datapath multiplier register.
REQ-007 clr  output  1  clear product register strobe.
REQ-008 ld  output  1  load multiplicand and multiplier registers strobe.
REQ-009 ldp  output  1  add multiplicand into product register strobe.
REQ-010 shp  output  1  shift product register strobe.
REQ-011 shb  output  1  shift multiplier register strobe.
REQ-012 busy  output  1  high in every state except IDLE and DONE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The controller SHALL implement states IDLE, CLR, LOAD, ADD, SHIFT, DONE.
REQ-015 IDLE SHALL move to CLR when start=1, else remain; all strobes 0.
REQ-016 CLR SHALL assert clr only, for exactly one cycle, then go to LOAD.
REQ-017 LOAD SHALL assert ld only, for exactly one cycle, clear bit counter to 0, then go to ADD.
REQ-018 ADD SHALL assert ldp combinationally equal to b_lsb, for exactly one cycle, then go to SHIFT.
REQ-019 SHIFT SHALL assert shp and shb together for one cycle. It SHALL go to DONE when the counter equals N-1. Otherwise it SHALL increment the counter and go to ADD.
REQ-020 DONE SHALL assert done for one cycle, all strobes 0, then go to IDLE.
REQ-021 Latency SHALL be fixed, independent of operand values. With start sampled at edge 0, done is high in cycle 2N+3; N=4 gives cycle 11.
REQ-022 Per operation, the controller SHALL produce exactly one clr, exactly one ld, exactly N shp/shb pulses, and between 0 and N ldp pulses.
REQ-023 No two of clr, ld, ldp and shp SHALL be high in the same cycle.
REQ-024 start SHALL be ignored in all states except IDLE, including DONE; no request is queued.
REQ-025 If abort=1 in CLR, LOAD, ADD or SHIFT, the next state SHALL be IDLE, with no done pulse. The strobe of the current cycle is still issued.
REQ-026 abort SHALL be ignored in IDLE and DONE. When abort and start are both high in IDLE, start wins.
REQ-027 The bit counter SHALL be ceil(log2(N)) bits wide and SHALL NOT wrap within an operation.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next edge, with all strobes 0.

Reset
REQ-029 reset_n=0 SHALL force state IDLE and counter 0 immediately, without waiting for a clock edge.
REQ-030 While in reset, clr, ld, ldp, shp, shb, busy and done SHALL all be 0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-032 The first start is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-033 Package mult_ctrl_pkg SHALL hold the state encoding type and the default N constant.
REQ-034 The bit counter SHALL be a sub-module mult_bit_cnt, with inputs clear, increment and N, and outputs count and last.
REQ-035 The state register SHALL be the only other sequential logic; all outputs SHALL be decoded from state, plus b_lsb for ldp.

Verification
REQ-036 N=4, start pulse, b_lsb=1 in every ADD -> sequence clr, ld, then (ldp, shp+shb) x4; done in cycle 11; busy high in cycles 1-10.
REQ-037 N=4, b_lsb pattern 1,0,1,1 across the ADD states -> ldp pulses in ADD #1, #3 and #4 only; done still in cycle 11.
REQ-038 start held high continuously for 30 cycles, N=4 -> back-to-back operations; second clr in the cycle after DONE's return to IDLE plus one; no start is accepted during busy or DONE.
REQ-039 abort=1 in the second SHIFT -> IDLE next cycle, no done pulse; a new start then completes a normal 11-cycle operation.
REQ-040 reset_n driven low mid-ADD, between clock edges -> all outputs 0 immediately; after release, a start completes normally.
REQ-041 N=2 and N=32 -> done in cycles 7 and 67 respectively; shp count equals N.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package mult_ctrl_pkg;

    // Default multiplier operand width in bits.
    localparam int N_DEFAULT = 4;

    // Controller state encoding. Encodings 6 and 7 are unreachable.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Bit-counter width: ceil(log2(n)), never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_bit_cnt.sv
// Bit counter for the multiplier controller: counts completed SHIFT steps.
// It saturates at N-1 so it can never wrap inside one operation.
module mult_bit_cnt
    import mult_ctrl_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          increment,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_VAL = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority, increment stops at the last bit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && (count_q != LAST_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for an N-bit sequential shift-add multiplier.
//
// Strobe protocol: start is a level request sampled only in IDLE; nothing is
// queued and there is no acknowledge besides busy going high on the next
// cycle. clr, ld, ldp, shp and shb are single-cycle, mutually exclusive
// datapath strobes (shp and shb always fire together). done is a one-cycle
// pulse after the last shift; an aborted or reset operation never pulses done.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          b_lsb,
    output logic          clr,
    output logic          ld,
    output logic          ldp,
    output logic          shp,
    output logic          shb,
    output logic          busy,
    output logic          done,
    output state_e        state_dbg,
    output logic [CW-1:0] cnt_dbg
);

    state_e state_q;
    state_e state_d;

    logic cnt_clear;
    logic cnt_inc;
    logic cnt_last;

    mult_bit_cnt #(
        .N(N)
    ) u_bit_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .increment(cnt_inc),
        .count    (cnt_dbg),
        .last     (cnt_last)
    );

    // Next-state and output decode; every strobe defaults low.
    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        ld        = 1'b0;
        ldp       = 1'b0;
        shp       = 1'b0;
        shb       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start beats a simultaneous abort here.
                if (start) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                clr     = 1'b1;
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                ld        = 1'b1;
                busy      = 1'b1;
                cnt_clear = 1'b1;
                state_d   = abort ? S_IDLE : S_ADD;
            end
            S_ADD: begin
                ldp     = b_lsb;
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                shp  = 1'b1;
                shb  = 1'b1;
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                // Illegal encodings recover to IDLE with all strobes low.
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed operations on an N=4
// instance checked cycle by cycle through an expected-output queue, plus
// N=2 and N=32 instances checked for done latency and strobe counts.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;
    import mult_ctrl_pkg::*;

    // Entry: {cycle[31:0], clr, ld, ldp, shp, shb, busy, done}
    localparam int W = 39;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- DUT signals ----------------
    logic start, abort, b_lsb;
    logic clr, ld, ldp, shp, shb, busy, done;
    state_e state_dbg;
    logic [1:0] cnt_dbg;

    logic start2, b2;
    logic clr2, ld2, ldp2, shp2, shb2, busy2, done2;
    state_e state2;
    logic [0:0] cnt2;

    logic start32, b32;
    logic clr32, ld32, ldp32, shp32, shb32, busy32, done32;
    state_e state32;
    logic [4:0] cnt32;

    mult_seq_ctrl #(.N(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .b_lsb(b_lsb),
        .clr(clr), .ld(ld), .ldp(ldp), .shp(shp), .shb(shb), .busy(busy), .done(done),
        .state_dbg(state_dbg), .cnt_dbg(cnt_dbg)
    );

    mult_seq_ctrl #(.N(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0), .b_lsb(b2),
        .clr(clr2), .ld(ld2), .ldp(ldp2), .shp(shp2), .shb(shb2), .busy(busy2), .done(done2),
        .state_dbg(state2), .cnt_dbg(cnt2)
    );

    mult_seq_ctrl #(.N(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .abort(1'b0), .b_lsb(b32),
        .clr(clr32), .ld(ld32), .ldp(ldp32), .shp(shp32), .shb(shb32), .busy(busy32), .done(done32),
        .state_dbg(state32), .cnt_dbg(cnt32)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [31:0]  exp2_q[$];
    logic [31:0]  exp32_q[$];
    bit           b_at[int];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int t, input logic [6:0] v);
        exp_q.push_back({32'(t), v});
    endtask

    // Expected N=4 operation whose start is driven during cycle c.
    // abort_shift = k stops the expectation after SHIFT #k (0 = no abort).
    task automatic push_op(input int c, input logic [3:0] bpat, input int abort_shift);
        int t;
        t = c + 1;
        push(t,     7'b1000010);
        push(t + 1, 7'b0100010);
        for (int i = 0; i < 4; i++) begin
            push(t + 2 + 2 * i, {2'b00, bpat[i], 4'b0010});
            b_at[t + 2 + 2 * i] = bpat[i];
            push(t + 3 + 2 * i, 7'b0001110);
            if (abort_shift == i + 1) return;
        end
        push(t + 10, 7'b0000001);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // ---------------- b_lsb drivers ----------------
    // Scheduled value in ADD cycles, random elsewhere (must be ignored there).
    initial begin
        b_lsb = 1'b0;
        b2    = 1'b0;
        b32   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            b_lsb = b_at.exists(cyc) ? b_at[cyc] : 1'($urandom_range(0, 1));
            b2    = 1'($urandom_range(0, 1));
            b32   = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor: N=4 instance ----------------
    initial begin
        logic [6:0]   vec;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            vec = {clr, ld, ldp, shp, shb, busy, done};
            while (exp_q.size() > 0 && int'(exp_q[0][W-1:7]) < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missing_out: got no output expected 0x%0h for cycle %0d", e[6:0], e[W-1:7]);
            end
            if (vec != 7'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(vec), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_cycle", 64'(cyc), 64'(e[W-1:7]));
                    check("out_vec", 64'(vec), 64'(e[6:0]));
                end
            end
        end
    end

    // ---------------- monitor: N=2 and N=32 instances ----------------
    initial begin
        int s2, c2, l2, p2, s32, c32, l32, p32;
        s2 = 0; c2 = 0; l2 = 0; p2 = 0;
        s32 = 0; c32 = 0; l32 = 0; p32 = 0;
        forever begin
            @(negedge clk);
            if (shp2 && shb2) s2++;
            if (clr2) c2++;
            if (ld2) l2++;
            if (ldp2) p2++;
            if (shp32 && shb32) s32++;
            if (clr32) c32++;
            if (ld32) l32++;
            if (ldp32) p32++;
            if (done2) begin
                if (exp2_q.size() == 0) begin
                    check("n2_unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("n2_done_cycle", 64'(cyc), 64'(exp2_q.pop_front()));
                    check("n2_shift_count", 64'(s2), 64'd2);
                    check("n2_clr_ld_count", 64'({c2[7:0], l2[7:0]}), 64'h0101);
                    check("n2_ldp_within_n", 64'(p2 <= 2), 64'd1);
                end
                s2 = 0; c2 = 0; l2 = 0; p2 = 0;
            end
            if (done32) begin
                if (exp32_q.size() == 0) begin
                    check("n32_unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("n32_done_cycle", 64'(cyc), 64'(exp32_q.pop_front()));
                    check("n32_shift_count", 64'(s32), 64'd32);
                    check("n32_clr_ld_count", 64'({c32[7:0], l32[7:0]}), 64'h0101);
                    check("n32_ldp_within_n", 64'(p32 <= 32), 64'd1);
                end
                s32 = 0; c32 = 0; l32 = 0; p32 = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        reset_n = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        start2  = 1'b0;
        start32 = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("reset_outs", 64'({clr, ld, ldp, shp, shb, busy, done}), 64'd0);
        check("reset_state", 64'(state_dbg), 64'(S_IDLE));
        check("reset_cnt", 64'(cnt_dbg), 64'd0);

        // Release reset and request in the same cycle: accepted on the first edge.
        wait_cycles(3);
        reset_n = 1'b1;
        start   = 1'b1;
        c = cyc;
        push_op(c, 4'b1111, 0);
        next_cycle();
        start = 1'b0;
        wait_cycles(14);

        // Pattern 1,0,1,1; stray starts during SHIFT and during DONE are ignored.
        start = 1'b1;
        c = cyc;
        push_op(c, 4'b1101, 0);
        for (int k = 1; k <= 14; k++) begin
            next_cycle();
            start = (k == 4 || k == 11);
        end
        start = 1'b0;
        wait_cycles(3);

        // abort alone in IDLE does nothing; abort with start in IDLE loses to start.
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        wait_cycles(2);
        start = 1'b1;
        abort = 1'b1;
        c = cyc;
        push_op(c, 4'b0110, 0);
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        wait_cycles(14);

        // abort during the second SHIFT, then a normal operation.
        start = 1'b1;
        c = cyc;
        push_op(c, 4'b0011, 2);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            start = 1'b0;
            abort = (k == 6);
        end
        abort = 1'b0;
        start = 1'b1;
        c = cyc;
        push_op(c, 4'b1000, 0);
        next_cycle();
        start = 1'b0;
        wait_cycles(14);

        // start held high for 30 cycles: back-to-back operations every 12 cycles.
        start = 1'b1;
        c = cyc;
        push_op(c,      4'b1010, 0);
        push_op(c + 12, 4'b0101, 0);
        push_op(c + 24, 4'b1001, 0);
        wait_cycles(30);
        start = 1'b0;
        wait_cycles(10);

        // Asynchronous reset in the middle of ADD #2.
        start = 1'b1;
        c = cyc;
        push_op(c, 4'b1111, 0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            start = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outs", 64'({clr, ld, ldp, shp, shb, busy, done}), 64'd0);
        check("async_reset_state", 64'(state_dbg), 64'(S_IDLE));
        check("async_reset_cnt", 64'(cnt_dbg), 64'd0);
        while (exp_q.size() > 0 && int'(exp_q[$][W-1:7]) >= c + 5) begin
            void'(exp_q.pop_back());
        end
        wait_cycles(2);
        #1 reset_n = 1'b1;
        start = 1'b1;
        c = cyc;
        push_op(c, 4'b0101, 0);
        next_cycle();
        start = 1'b0;
        wait_cycles(14);

        // N=2 and N=32 latency.
        start2  = 1'b1;
        start32 = 1'b1;
        c = cyc;
        exp2_q.push_back(32'(c + 7));
        exp32_q.push_back(32'(c + 67));
        next_cycle();
        start2  = 1'b0;
        start32 = 1'b0;
        wait_cycles(68);

        // Bounded drain of all expectation queues.
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && exp2_q.size() == 0 && exp32_q.size() == 0) break;
            next_cycle();
        end
        check("queues_drained", 64'(exp_q.size() + exp2_q.size() + exp32_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
